// File: rtl/axi_sram_slave.sv
// AXI4 responder over a word-addressed register memory; independent write and read engines, one burst each.
// Write: AW, 1 cycle per W beat, then B. Read: first beat the cycle after AR, 1 beat/cycle while RREADY; outputs held under stall.
module axi_sram_slave #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [AXI_ID_WIDTH-1:0]     AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                  AWLEN,
    input  logic [2:0]                  AWSIZE,
    input  logic [1:0]                  AWBURST,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ID_WIDTH-1:0]     ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [AXI_ID_WIDTH-1:0]     RID,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY
);
    localparam int AW    = AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << AW;
    localparam int NB    = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w, input logic [7:0] len,
                                                input logic [1:0] burst);
        logic [AW-1:0] m;
        logic [AW-1:0] inc;
        m   = AW'(len);
        inc = w + {{(AW-1){1'b0}}, 1'b1};
        case (burst)
            2'b00:   return w;
            2'b10:   return (w & ~m) | (inc & m);
            default: return inc;
        endcase
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    logic          unused_addr_bits;
    logic          aw_err, ar_err, wr_en;
    logic [AW-1:0] ar_word;

    assign unused_addr_bits = &{1'b0, AWADDR[1:0], ARADDR[1:0]};
    assign aw_err  = burst_err(AWLEN, AWSIZE, AWBURST);
    assign ar_err  = burst_err(ARLEN, ARSIZE, ARBURST);
    assign ar_word = ARADDR[AXI_ADDR_WIDTH-1:2];

    // ---------------- write engine ----------------
    w_state_t      w_state;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_len;
    logic [1:0]    w_burst;
    logic          w_err;
    logic [8:0]    w_cnt;   // one bit wider than AWLEN so overlong bursts stay distinguishable

    assign wr_en = ARESETN && WREADY && WVALID && !w_err && (w_cnt <= {1'b0, w_len});

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem[w_addr][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= 2'b00;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_cnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        BID     <= AWID;
                        w_addr  <= AWADDR[AXI_ADDR_WIDTH-1:2];
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_err   <= aw_err;
                        w_cnt   <= '0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY) begin
                        w_addr <= next_word(w_addr, w_len, w_burst);
                        if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
                        if (WLAST) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= (w_err || w_cnt != {1'b0, w_len}) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    r_state_t      r_state;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt;
    logic [1:0]    r_burst;
    logic          r_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            RLAST   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RID     <= ARID;
                        RDATA   <= ar_err ? '0 : mem[ar_word];
                        RRESP   <= ar_err ? 2'b10 : 2'b00;
                        RLAST   <= (ARLEN == 8'd0);
                        r_addr  <= next_word(ar_word, ARLEN, ARBURST);
                        r_len   <= ARLEN;
                        r_cnt   <= 8'd0;
                        r_burst <= ARBURST;
                        r_err   <= ar_err;
                        r_state <= R_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            // Memory read here sees pre-write contents if the write engine commits this edge.
                            RDATA  <= r_err ? '0 : mem[r_addr];
                            r_addr <= next_word(r_addr, r_len, r_burst);
                            r_cnt  <= r_cnt + 8'd1;
                            RLAST  <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed bursts push expected B/R responses, a negedge monitor pops and compares.
module tb_axi_sram_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [7:0]  AWADDR, ARADDR, AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    always #5 ACLK = ~ACLK;

    axi_sram_slave #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct { logic [0:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [0:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;

    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [31:0] wdat [64];
    logic [3:0]  wstr [64];
    logic [31:0] rexp [64];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got no response, expected one within the cycle budget", name);
    endtask

    // Monitor: handshakes pop the scoreboard; stalled beats are held against the head entry.
    always @(negedge ACLK) begin : monitor
        bexp_t be;
        rexp_t re;
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) fail_now("unexpected_B");
                else begin
                    be = bq.pop_front();
                    chk("bid", BID, be.id);
                    chk("bresp", BRESP, be.resp);
                end
            end
            if (RVALID && rq.size() == 0 && RREADY) fail_now("unexpected_R");
            else if (RVALID && rq.size() != 0) begin
                if (RREADY) begin
                    re = rq.pop_front();
                    chk("rid", RID, re.id);
                    chk("rdata", RDATA, re.data);
                    chk("rresp", RRESP, re.resp);
                    chk("rlast", RLAST, re.last);
                end else begin
                    chk("rdata_stall", RDATA, rq[0].data);
                    chk("rlast_stall", RLAST, rq[0].last);
                end
            end
        end
    end

    task automatic axi_write(input logic [0:0] id, input logic [7:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                             input logic [1:0] resp);
        int to;
        bq.push_back('{id: id, resp: resp});
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size;
        to = 0;
        while (!AWREADY && to < 100) begin @(posedge ACLK); #1; to++; end
        if (to >= 100) fail_now("aw_handshake");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            WVALID = 1'b1; WDATA = wdat[i]; WSTRB = wstr[i]; WLAST = (i == nbeats - 1);
            to = 0;
            while (!WREADY && to < 100) begin @(posedge ACLK); #1; to++; end
            if (to >= 100) fail_now("w_handshake");
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        to = 0;
        while (bq.size() > 0 && to < 100) begin @(posedge ACLK); #1; to++; end
        if (bq.size() > 0) begin fail_now("b_response"); bq.delete(); end
    endtask

    task automatic axi_read(input logic [0:0] id, input logic [7:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [1:0] resp,
                            input bit toggle, input int abort_after);
        int to;
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{id: id, data: rexp[i], resp: resp, last: (i == int'(len))});
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size;
        to = 0;
        while (!ARREADY && to < 100) begin @(posedge ACLK); #1; to++; end
        if (to >= 100) fail_now("ar_handshake");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        to = 0;
        while (rq.size() > 0 && to < 500) begin
            if (abort_after > 0 && (int'(len) + 1 - rq.size()) >= abort_after) begin
                // Reset lands with the next beat already presented
                RREADY = 1'b0; ARESETN = 1'b0; rq.delete();
                @(posedge ACLK);
                @(negedge ACLK);
                chk("rst_rvalid", RVALID, 1'b0);
                chk("rst_arready", ARREADY, 1'b0);
                chk("rst_rlast", RLAST, 1'b0);
                @(posedge ACLK); #1;
                ARESETN = 1'b1;
                @(posedge ACLK);
                @(negedge ACLK);
                chk("post_rst_arready", ARREADY, 1'b1);
                chk("post_rst_awready", AWREADY, 1'b1);
                chk("post_rst_rvalid", RVALID, 1'b0);
                break;
            end
            if (toggle) RREADY = ~RREADY;
            @(posedge ACLK); #1;
            to++;
        end
        if (rq.size() > 0) begin fail_now("r_beats"); rq.delete(); end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
    endtask

    initial begin
        ARESETN = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_awready", AWREADY, 1'b0);
        chk("reset_arready", ARREADY, 1'b0);
        chk("reset_wready", WREADY, 1'b0);
        chk("reset_bvalid", BVALID, 1'b0);
        chk("reset_rvalid", RVALID, 1'b0);
        chk("reset_rdata", RDATA, 32'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("first_awready", AWREADY, 1'b1);
        chk("first_arready", ARREADY, 1'b1);

        // Single beat write then read back
        wdat[0] = 32'h0000_0003; wstr[0] = 4'hF;
        axi_write(1'b0, 8'h00, 8'd0, 2'b01, 3'b010, 1, 2'b00);
        rexp[0] = 32'h0000_0003;
        axi_read(1'b1, 8'h00, 8'd0, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // FIXED burst with partial strobe on the second beat
        wdat[0] = 32'h1111_1111; wstr[0] = 4'hF;
        wdat[1] = 32'h2222_2222; wstr[1] = 4'b0011;
        axi_write(1'b1, 8'h20, 8'd1, 2'b00, 3'b010, 2, 2'b00);
        rexp[0] = 32'h1111_2222;
        axi_read(1'b0, 8'h20, 8'd0, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // WRAP L=8 starting at word 5
        for (int i = 0; i < 8; i++) begin wdat[i] = 32'hA0A0_0000 + i; wstr[i] = 4'hF; end
        axi_write(1'b0, 8'h14, 8'd7, 2'b10, 3'b010, 8, 2'b00);
        for (int i = 0; i < 8; i++) rexp[i] = 32'hA0A0_0000 + ((i + 3) % 8);
        axi_read(1'b0, 8'h00, 8'd7, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // INCR across the top of memory: word 63 then word 0
        wdat[0] = 32'h6363_6363; wdat[1] = 32'h00FF_00FF;
        axi_write(1'b1, 8'hFC, 8'd1, 2'b01, 3'b010, 2, 2'b00);
        rexp[0] = 32'h6363_6363; rexp[1] = 32'h00FF_00FF;
        axi_read(1'b1, 8'hFC, 8'd1, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // INCR L=32 at word 16, read 8 back with RREADY toggling
        for (int i = 0; i < 32; i++) begin wdat[i] = 32'hB000_0000 + i; wstr[i] = 4'hF; end
        axi_write(1'b0, 8'h40, 8'd31, 2'b01, 3'b010, 32, 2'b00);
        for (int i = 0; i < 8; i++) rexp[i] = 32'hB000_0000 + i;
        axi_read(1'b1, 8'h40, 8'd7, 2'b01, 3'b010, 2'b00, 1'b1, 0);

        // Reserved burst type: SLVERR, memory untouched
        wdat[0] = 32'hDEAD_0000; wdat[1] = 32'hDEAD_0001;
        axi_write(1'b1, 8'h40, 8'd1, 2'b11, 3'b010, 2, 2'b10);
        rexp[0] = 32'hB000_0000; rexp[1] = 32'hB000_0001;
        axi_read(1'b0, 8'h40, 8'd1, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // Bad ARSIZE and WRAP with L=3: zero data, SLVERR on every beat
        for (int i = 0; i < 4; i++) rexp[i] = 32'h0;
        axi_read(1'b1, 8'h40, 8'd3, 2'b01, 3'b001, 2'b10, 1'b0, 0);
        axi_read(1'b0, 8'h40, 8'd2, 2'b10, 3'b010, 2'b10, 1'b0, 0);

        // Early WLAST on beat 2 of an AWLEN=3 write
        for (int i = 0; i < 3; i++) begin wdat[i] = 32'hC000_0000 + i; wstr[i] = 4'hF; end
        axi_write(1'b0, 8'h80, 8'd3, 2'b01, 3'b010, 3, 2'b10);
        rexp[0] = 32'hC000_0000; rexp[1] = 32'hC000_0001; rexp[2] = 32'hC000_0002; rexp[3] = 32'hB000_0013;
        axi_read(1'b0, 8'h80, 8'd3, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // Beat past AWLEN is accepted but not written
        wdat[0] = 32'hE000_0000; wdat[1] = 32'hE000_0001;
        axi_write(1'b1, 8'hA0, 8'd0, 2'b01, 3'b010, 2, 2'b10);
        rexp[0] = 32'hE000_0000; rexp[1] = 32'hB000_0019;
        axi_read(1'b1, 8'hA0, 8'd1, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        // Reset after beat 3 of 8, then a fresh read
        for (int i = 0; i < 8; i++) rexp[i] = 32'hB000_0000 + i;
        axi_read(1'b0, 8'h40, 8'd7, 2'b01, 3'b010, 2'b00, 1'b0, 3);
        rexp[0] = 32'hC000_0000; rexp[1] = 32'hC000_0001;
        axi_read(1'b1, 8'h80, 8'd1, 2'b01, 3'b010, 2'b00, 1'b0, 0);

        repeat (3) @(posedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
